// File: rtl/timer_controller.sv
// CHIP-8 delay/sound timer sequencer with a 60 Hz prescaler and square-wave tone generator.
// Latency: loads visible 1 cycle after the write enable; tick_60 and the decremented value appear together.
// Backpressure: none; loads are always accepted and take priority over a coincident tick.
module timer_controller #(
    parameter int TICK_DIV = 833333,
    parameter int TONE_DIV = 113636
) (
    input  logic       cpu_clk,
    input  logic       reset,
    input  logic       freeze,
    input  logic       delay_we,
    input  logic       sound_we,
    input  logic [7:0] data_in,
    output logic [7:0] delay_out,
    output logic       delay_active,
    output logic       sound_on,
    output logic       tone_out,
    output logic       tick_60
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int TW = $clog2(TONE_DIV) + 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

    logic [PW-1:0] pre_cnt;
    logic [TW-1:0] tone_cnt;
    logic [7:0]    sound_q;
    logic          tick;

    // A tick fires on the last prescaler count unless the prescaler is frozen.
    assign tick         = (pre_cnt == PRE_LAST) && !freeze;
    assign delay_active = (delay_out != 8'd0);
    assign sound_on     = (sound_q != 8'd0);

    // Prescaler: wraps on tick, advances when running, holds its count while frozen.
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else if (!freeze) begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // Registered tick marker, aligned with the edge on which the timers decrement.
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            tick_60 <= 1'b0;
        end else begin
            tick_60 <= tick;
        end
    end

    // Delay timer: a load beats the tick; decrement saturates at zero.
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            delay_out <= 8'd0;
        end else if (delay_we) begin
            delay_out <= data_in;
        end else if (tick && (delay_out != 8'd0)) begin
            delay_out <= delay_out - 8'd1;
        end
    end

    // Sound timer: same arbitration as the delay timer.
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            sound_q <= 8'd0;
        end else if (sound_we) begin
            sound_q <= data_in;
        end else if (tick && (sound_q != 8'd0)) begin
            sound_q <= sound_q - 8'd1;
        end
    end

    // Tone divider runs only while the buzzer is on, independent of freeze, and parks low otherwise.
    always_ff @(posedge cpu_clk) begin
        if (reset || !sound_on) begin
            tone_cnt <= '0;
            tone_out <= 1'b0;
        end else if (tone_cnt == TONE_LAST) begin
            tone_cnt <= '0;
            tone_out <= ~tone_out;
        end else begin
            tone_cnt <= tone_cnt + TW'(1);
        end
    end

endmodule

// File: tb/tb_timer_controller.sv
// Testbench for timer_controller with TICK_DIV=4, TONE_DIV=2.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is driven every cycle.
module tb_timer_controller;

    localparam int TICK_DIV = 4;
    localparam int TONE_DIV = 2;

    logic       cpu_clk = 1'b0;
    logic       reset = 1'b1;
    logic       freeze = 1'b0;
    logic       delay_we = 1'b0;
    logic       sound_we = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic [7:0] delay_out;
    logic       delay_active;
    logic       sound_on;
    logic       tone_out;
    logic       tick_60;

    int checks = 0;
    int errors = 0;

    // Reference model state: non-frozen edges since reset, timer values, cycles of continuous sound.
    int         m_run = 0;
    logic [7:0] m_delay = 8'd0;
    logic [7:0] m_sound = 8'd0;
    int         m_sound_cycles = 0;
    logic       m_tone = 1'b0;
    logic       m_tick60 = 1'b0;

    timer_controller #(.TICK_DIV(TICK_DIV), .TONE_DIV(TONE_DIV)) dut (
        .cpu_clk     (cpu_clk),
        .reset       (reset),
        .freeze      (freeze),
        .delay_we    (delay_we),
        .sound_we    (sound_we),
        .data_in     (data_in),
        .delay_out   (delay_out),
        .delay_active(delay_active),
        .sound_on    (sound_on),
        .tone_out    (tone_out),
        .tick_60     (tick_60)
    );

    always #5 cpu_clk = ~cpu_clk;

    wire [11:0] dut_vec = {delay_out, delay_active, sound_on, tone_out, tick_60};

    function automatic logic [11:0] model_vec();
        return {m_delay, m_delay != 8'd0, m_sound != 8'd0, m_tone, m_tick60};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, then settle before sampling.
    task automatic step(input bit r, input bit f, input bit dw, input bit sw, input logic [7:0] d);
        bit t;
        bit snd_before;
        reset = r; freeze = f; delay_we = dw; sound_we = sw; data_in = d;
        @(posedge cpu_clk);
        t = !f && ((m_run % TICK_DIV) == TICK_DIV - 1);
        snd_before = (m_sound != 8'd0);
        if (r) begin
            m_run = 0; m_delay = 8'd0; m_sound = 8'd0;
            m_sound_cycles = 0; m_tone = 1'b0; m_tick60 = 1'b0;
        end else begin
            if (!f) m_run = (m_run + 1) % TICK_DIV;
            if (dw) m_delay = d;
            else if (t && m_delay != 8'd0) m_delay = m_delay - 8'd1;
            if (sw) m_sound = d;
            else if (t && m_sound != 8'd0) m_sound = m_sound - 8'd1;
            m_tick60 = t;
            if (snd_before) begin
                m_sound_cycles++;
                m_tone = ((m_sound_cycles / TONE_DIV) % 2) == 1;
            end else begin
                m_sound_cycles = 0;
                m_tone = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 8'd0);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 8'd0);
        step(1, 0, 0, 0, 8'd0);
        checks++;
        if (dut_vec !== 12'h000) begin
            errors++;
            $display("FAIL reset_state got %h exp %h", dut_vec, 12'h000);
        end
    endtask

    task automatic test_idle();
        int pulses = 0;
        for (int i = 0; i < 20; i++) begin
            idle();
            if (tick_60 === 1'b1) pulses++;
            checks++;
            if (dut_vec !== model_vec() || delay_out === 8'hFF) begin
                errors++;
                $display("FAIL idle_cycle%0d got %h exp %h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (pulses !== 5) begin
            errors++;
            $display("FAIL idle_tick_count got %0d exp %0d", pulses, 5);
        end
    endtask

    task automatic test_delay_countdown();
        logic [7:0] seen [$];
        logic [7:0] want [3];
        want = '{8'd2, 8'd1, 8'd0};
        step(0, 0, 1, 0, 8'd3);
        checks++;
        if (delay_out !== 8'd3 || delay_active !== 1'b1) begin
            errors++;
            $display("FAIL countdown_load got %0d/%b exp 3/1", delay_out, delay_active);
        end
        for (int i = 0; i < 16 && seen.size() < 3; i++) begin
            idle();
            if (tick_60 === 1'b1) seen.push_back(delay_out);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL countdown_cycle%0d got %h exp %h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (seen.size() != 3) begin
            errors++;
            $display("FAIL countdown_timeout got %0d ticks exp 3", seen.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (seen[k] !== want[k]) begin
                    errors++;
                    $display("FAIL countdown_tick%0d got %0d exp %0d", k, seen[k], want[k]);
                end
            end
        end
        checks++;
        if (delay_active !== 1'b0) begin
            errors++;
            $display("FAIL countdown_active_fall got %b exp 0", delay_active);
        end
    endtask

    task automatic test_load_on_tick();
        for (int i = 0; i < TICK_DIV && (m_run % TICK_DIV) != 1; i++) idle();
        step(0, 0, 1, 0, 8'd2);
        idle();
        checks++;
        if (delay_out !== 8'd2) begin
            errors++;
            $display("FAIL load_tick_pre got %0d exp 2", delay_out);
        end
        step(0, 0, 1, 0, 8'd5);
        checks++;
        if (delay_out !== 8'd5 || tick_60 !== 1'b1) begin
            errors++;
            $display("FAIL load_tick_win got %0d/%b exp 5/1", delay_out, tick_60);
        end
        for (int i = 0; i < 4; i++) idle();
        checks++;
        if (delay_out !== 8'd4 || tick_60 !== 1'b1) begin
            errors++;
            $display("FAIL load_tick_next got %0d/%b exp 4/1", delay_out, tick_60);
        end
    endtask

    task automatic test_simultaneous();
        bit got_tick = 0;
        step(0, 0, 1, 1, 8'd1);
        checks++;
        if (delay_out !== 8'd1 || sound_on !== 1'b1) begin
            errors++;
            $display("FAIL simul_load got %0d/%b exp 1/1", delay_out, sound_on);
        end
        for (int i = 0; i < 8 && !got_tick; i++) begin
            idle();
            got_tick = (tick_60 === 1'b1);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL simul_cycle%0d got %h exp %h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (!got_tick || delay_out !== 8'd0 || sound_on !== 1'b0) begin
            errors++;
            $display("FAIL simul_zero got tick=%b %0d/%b exp tick=1 0/0", got_tick, delay_out, sound_on);
        end
        idle();
        idle();
        checks++;
        if (tone_out !== 1'b0) begin
            errors++;
            $display("FAIL simul_tone_off got %b exp 0", tone_out);
        end
    endtask

    task automatic test_freeze();
        for (int i = 0; i < TICK_DIV && (m_run % TICK_DIV) != 1; i++) idle();
        step(0, 0, 1, 0, 8'd4);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) step(0, 1, 1, 0, 8'd7);
            else step(0, 1, 0, 0, 8'd0);
            checks++;
            if (tick_60 !== 1'b0 || delay_out !== ((i < 5) ? 8'd4 : 8'd7)) begin
                errors++;
                $display("FAIL freeze_cycle%0d got %0d/%b exp %0d/0", i, delay_out, tick_60,
                         (i < 5) ? 4 : 7);
            end
        end
        idle();
        checks++;
        if (tick_60 !== 1'b0) begin
            errors++;
            $display("FAIL freeze_resume_early got %b exp 0", tick_60);
        end
        idle();
        checks++;
        if (tick_60 !== 1'b1 || delay_out !== 8'd6) begin
            errors++;
            $display("FAIL freeze_resume_tick got %b/%0d exp 1/6", tick_60, delay_out);
        end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 1, 1, 8'd9);
        idle();
        step(1, 0, 1, 0, 8'd200);
        checks++;
        if (dut_vec !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid got %h exp %h", dut_vec, 12'h000);
        end
        for (int i = 1; i <= 4; i++) begin
            idle();
            checks++;
            if (tick_60 !== (i == 4)) begin
                errors++;
                $display("FAIL reset_restart_cycle%0d got %b exp %b", i, tick_60, i == 4);
            end
        end
    endtask

    task automatic test_random();
        bit r, f, dw, sw;
        logic [7:0] d;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 59) == 0);
            f  = ($urandom_range(0, 5) == 0);
            dw = ($urandom_range(0, 7) == 0);
            sw = ($urandom_range(0, 7) == 0);
            d  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            step(r, f, dw, sw, d);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d got %h exp %h", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_delay_countdown();
        test_load_on_tick();
        test_simultaneous();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
